mem_stack_unit: RTL and testbench

// Memory-stage access unit of the 5-stage pipeline. Consumes the control unit's

---
 rtl/mem_stack_unit_pkg.sv | 25 ++
 rtl/mem_stack_unit_stack_pointer.sv | 43 ++++
 rtl/mem_stack_unit.sv | 136 +++++++++++++
 tb/tb_mem_stack_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stack_unit_pkg.sv
// Shared definitions for the memory-stage access unit: write-source selects,
// read-response tags and the condition-code width.
package mem_stack_unit_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;
    localparam int CCR_W      = 3;

    typedef enum logic [1:0] {
        SEL_DATA  = 2'b00,
        SEL_PC_HI = 2'b01,
        SEL_PC_LO = 2'b10,
        SEL_CCR   = 2'b11
    } data_sel_e;

    // Identifies what the word coming back from memory next cycle belongs to.
    typedef enum logic [2:0] {
        TAG_NONE = 3'd0,
        TAG_LOAD = 3'd1,
        TAG_PC1  = 3'd2,
        TAG_PC2  = 3'd3,
        TAG_CCR  = 3'd4
    } read_tag_e;

endpackage

// File: rtl/mem_stack_unit_stack_pointer.sv
// Stack pointer register: post-decrement on push, pre-increment on pop.
// The caller only asserts push_i/pop_i for accesses that are legal.
module stack_pointer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W-1:0] sp_inc_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W-1:0] SP_RESET = '1;

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (push_i) begin
            sp_d = sp_q - 1'b1;
        end else if (pop_i) begin
            sp_d = sp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= SP_RESET;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o     = sp_q;
    assign sp_inc_o = sp_q + 1'b1;
    assign full_o   = (sp_q == '0);
    assign empty_o  = (sp_q == SP_RESET);

endmodule

// File: rtl/mem_stack_unit.sv
// Memory-stage access unit: drives the data-memory port, owns the stack pointer
// and turns read responses into load data, a return PC or a restored CCR.
module mem_stack_unit
    import mem_stack_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              stack,
    input  logic [1:0]        mem_data_sel,
    input  logic              pop_pc1,
    input  logic              pop_pc2,
    input  logic              pop_ccr,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [31:0]       pc_in,
    input  logic [CCR_W-1:0]  ccr_in,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic [31:0]       ret_pc,
    output logic              ret_pc_valid,
    output logic [CCR_W-1:0]  ccr_restore,
    output logic              ccr_restore_valid,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_fault
);

    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_inc;
    logic              sp_full;
    logic              sp_empty;

    logic push_req, pop_req, push_ok, pop_ok, read_ok, fault_set;

    read_tag_e         tag_q, tag_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              fault_q, fault_d;

    // A simultaneous read and write is resolved in favour of the write.
    assign push_req  = mem_write & stack;
    assign pop_req   = mem_read & stack & ~mem_write;
    assign push_ok   = push_req & ~sp_full;
    assign pop_ok    = pop_req & ~sp_empty;
    assign read_ok   = mem_read & ~mem_write & (~stack | ~sp_empty);
    assign fault_set = (push_req & sp_full) | (pop_req & sp_empty) | (mem_read & mem_write);

    stack_pointer #(
        .ADDR_W (ADDR_W)
    ) u_sp (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push_ok),
        .pop_i    (pop_ok),
        .sp_o     (sp),
        .sp_inc_o (sp_inc),
        .full_o   (sp_full),
        .empty_o  (sp_empty)
    );

    always_comb begin
        dmem_addr = alu_result;
        if (stack) begin
            dmem_addr = mem_write ? sp : sp_inc;
        end
    end

    always_comb begin
        dmem_wdata = store_data;
        case (mem_data_sel)
            SEL_PC_HI: dmem_wdata = DATA_W'(pc_in[31:16]);
            SEL_PC_LO: dmem_wdata = DATA_W'(pc_in[15:0]);
            SEL_CCR:   dmem_wdata = {{(DATA_W-CCR_W){1'b0}}, ccr_in};
            default:   dmem_wdata = store_data;
        endcase
    end

    assign dmem_we = mem_write & (~stack | ~sp_full);
    assign dmem_re = read_ok;

    // pop_* strobes only matter for stack reads; pc1 outranks pc2 outranks ccr.
    always_comb begin
        tag_d = TAG_NONE;
        if (read_ok) begin
            tag_d = TAG_LOAD;
            if (stack) begin
                if (pop_pc1) begin
                    tag_d = TAG_PC1;
                end else if (pop_pc2) begin
                    tag_d = TAG_PC2;
                end else if (pop_ccr) begin
                    tag_d = TAG_CCR;
                end
            end
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (tag_q == TAG_PC2) begin
            hold_d = dmem_rdata;
        end
    end

    assign fault_d = fault_q | fault_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= TAG_NONE;
            hold_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            hold_q  <= hold_d;
            fault_q <= fault_d;
        end
    end

    assign load_valid        = (tag_q == TAG_LOAD);
    assign ret_pc_valid      = (tag_q == TAG_PC1);
    assign ccr_restore_valid = (tag_q == TAG_CCR);
    assign load_data         = load_valid ? dmem_rdata : '0;
    assign ret_pc            = ret_pc_valid ? {dmem_rdata[15:0], hold_q[15:0]} : '0;
    assign ccr_restore       = ccr_restore_valid ? dmem_rdata[CCR_W-1:0] : '0;
    assign sp_out            = sp;
    assign stack_fault       = fault_q;

endmodule

// File: tb/tb_mem_stack_unit.sv
// Bench for mem_stack_unit: directed CALL/RET/INT/RTI and fault scenarios plus
// randomized push/pop/load/store traffic against a queue-based stack model.
module tb_mem_stack_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 0, mem_write = 0, stack = 0;
    logic [1:0]  mem_data_sel = 0;
    logic        pop_pc1 = 0, pop_pc2 = 0, pop_ccr = 0;
    logic [11:0] alu_result = 0;
    logic [15:0] store_data = 0;
    logic [31:0] pc_in = 0;
    logic [2:0]  ccr_in = 0;
    logic [11:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_we, dmem_re;
    logic [15:0] dmem_rdata = 0;
    logic [15:0] load_data;
    logic        load_valid;
    logic [31:0] ret_pc;
    logic        ret_pc_valid;
    logic [2:0]  ccr_restore;
    logic        ccr_restore_valid;
    logic [11:0] sp_out;
    logic        stack_fault;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:4095];
    logic [15:0] exp_q[$];

    typedef struct {
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        we, re;
        logic        lv;
        logic [15:0] ld;
        logic        rv;
        logic [31:0] rpc;
        logic        cv;
        logic [2:0]  ccr;
        logic [11:0] sp;
        logic        fault;
    } snap_t;

    mem_stack_unit dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .stack(stack),
        .mem_data_sel(mem_data_sel),
        .pop_pc1(pop_pc1), .pop_pc2(pop_pc2), .pop_ccr(pop_ccr),
        .alu_result(alu_result), .store_data(store_data),
        .pc_in(pc_in), .ccr_in(ccr_in),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
        .load_data(load_data), .load_valid(load_valid),
        .ret_pc(ret_pc), .ret_pc_valid(ret_pc_valid),
        .ccr_restore(ccr_restore), .ccr_restore_valid(ccr_restore_valid),
        .sp_out(sp_out), .stack_fault(stack_fault)
    );

    // ---------------- clock / memory / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_we) mem[dmem_addr] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= mem[dmem_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst = 1'b1;
        {mem_read, mem_write, stack, pop_pc1, pop_pc2, pop_ccr} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic rd, input logic wr, input logic stk, input logic [1:0] sel,
                        input logic p1, input logic p2, input logic pc,
                        input logic [11:0] alu, input logic [15:0] sd,
                        input logic [31:0] pcv, input logic [2:0] cv, output snap_t s);
        mem_read = rd; mem_write = wr; stack = stk; mem_data_sel = sel;
        pop_pc1 = p1; pop_pc2 = p2; pop_ccr = pc;
        alu_result = alu; store_data = sd; pc_in = pcv; ccr_in = cv;
        @(negedge clk);
        s.addr = dmem_addr; s.wdata = dmem_wdata; s.we = dmem_we; s.re = dmem_re;
        s.lv = load_valid; s.ld = load_data; s.rv = ret_pc_valid; s.rpc = ret_pc;
        s.cv = ccr_restore_valid; s.ccr = ccr_restore; s.sp = sp_out; s.fault = stack_fault;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [15:0] sd, input logic [31:0] pcv,
                        input logic [2:0] cv, output snap_t s);
        step(0, 1, 1, sel, 0, 0, 0, 12'h0, sd, pcv, cv, s);
    endtask

    task automatic pop(input logic p1, input logic p2, input logic pc, output snap_t s);
        step(1, 0, 1, 2'b00, p1, p2, pc, 12'h0, 16'h0, 32'h0, 3'h0, s);
    endtask

    task automatic idle(output snap_t s);
        step(0, 0, 0, 2'b00, 0, 0, 0, 12'h0, 16'h0, 32'h0, 3'h0, s);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        snap_t s;
        do_reset();
        idle(s);
        checks++; if (s.sp !== 12'hFFF) begin errors++; $display("FAIL reset_sp: got %h want fff", s.sp); end
        checks++; if ({s.lv, s.rv, s.cv} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {s.lv, s.rv, s.cv}); end
        checks++; if (s.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", s.fault); end
        checks++; if ({s.we, s.re} !== 2'b00) begin errors++; $display("FAIL reset_we_re: got %b want 00", {s.we, s.re}); end
        checks++; if ({s.ld, s.rpc, s.ccr} !== '0) begin errors++; $display("FAIL reset_data: ld=%h rpc=%h ccr=%h want 0", s.ld, s.rpc, s.ccr); end
    endtask

    task automatic test_call_ret;
        snap_t s;
        push(2'b01, 16'h0, 32'h0001_2345, 3'h0, s);
        checks++; if ({s.we, s.addr, s.wdata} !== {1'b1, 12'hFFF, 16'h0001}) begin errors++; $display("FAIL call_hi: we=%b addr=%h wdata=%h want 1 fff 0001", s.we, s.addr, s.wdata); end
        push(2'b10, 16'h0, 32'h0001_2345, 3'h0, s);
        checks++; if ({s.we, s.addr, s.wdata} !== {1'b1, 12'hFFE, 16'h2345}) begin errors++; $display("FAIL call_lo: we=%b addr=%h wdata=%h want 1 ffe 2345", s.we, s.addr, s.wdata); end
        idle(s);
        checks++; if (s.sp !== 12'hFFD) begin errors++; $display("FAIL call_sp: got %h want ffd", s.sp); end
        checks++; if ({mem[12'hFFF], mem[12'hFFE]} !== 32'h0001_2345) begin errors++; $display("FAIL call_mem: got %h%h want 00012345", mem[12'hFFF], mem[12'hFFE]); end
        pop(0, 1, 0, s);
        checks++; if ({s.re, s.addr} !== {1'b1, 12'hFFE}) begin errors++; $display("FAIL ret_pc2_issue: re=%b addr=%h want 1 ffe", s.re, s.addr); end
        pop(1, 0, 0, s);
        checks++; if ({s.re, s.addr, s.rv} !== {1'b1, 12'hFFF, 1'b0}) begin errors++; $display("FAIL ret_pc1_issue: re=%b addr=%h rv=%b want 1 fff 0", s.re, s.addr, s.rv); end
        idle(s);
        checks++; if ({s.rv, s.rpc} !== {1'b1, 32'h0001_2345}) begin errors++; $display("FAIL ret_pc: rv=%b pc=%h want 1 00012345", s.rv, s.rpc); end
        checks++; if (s.sp !== 12'hFFF) begin errors++; $display("FAIL ret_sp: got %h want fff", s.sp); end
        idle(s);
        checks++; if (s.rv !== 1'b0) begin errors++; $display("FAIL ret_pulse: rv=%b want 0", s.rv); end
    endtask

    task automatic test_int_rti;
        snap_t s;
        push(2'b01, 16'h0, 32'h0000_00A0, 3'b101, s);
        push(2'b10, 16'h0, 32'h0000_00A0, 3'b101, s);
        push(2'b11, 16'hFFFF, 32'h0000_00A0, 3'b101, s);
        checks++; if ({s.addr, s.wdata} !== {12'hFFD, 16'h0005}) begin errors++; $display("FAIL int_ccr_push: addr=%h wdata=%h want ffd 0005", s.addr, s.wdata); end
        pop(0, 0, 1, s);
        checks++; if (s.addr !== 12'hFFD) begin errors++; $display("FAIL rti_ccr_addr: got %h want ffd", s.addr); end
        pop(0, 1, 0, s);
        checks++; if ({s.cv, s.ccr} !== {1'b1, 3'd5}) begin errors++; $display("FAIL rti_ccr: cv=%b ccr=%0d want 1 5", s.cv, s.ccr); end
        pop(1, 0, 0, s);
        checks++; if ({s.cv, s.rv} !== 2'b00) begin errors++; $display("FAIL rti_mid: cv=%b rv=%b want 0 0", s.cv, s.rv); end
        idle(s);
        checks++; if ({s.rv, s.rpc, s.sp} !== {1'b1, 32'h0000_00A0, 12'hFFF}) begin errors++; $display("FAIL rti_pc: rv=%b pc=%h sp=%h want 1 000000a0 fff", s.rv, s.rpc, s.sp); end
    endtask

    task automatic test_random;
        snap_t s;
        logic [15:0] stk[$];
        logic [15:0] ram_m [int];
        logic [11:0] addrs[$];
        logic pend, next_pend;
        logic [11:0] a;
        logic [15:0] d, e;
        logic [11:0] exp_sp;
        int op;
        pend = 0;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 4);
            if (op == 1 && stk.size() == 0) op = 0;
            if (op == 0 && stk.size() >= 50) op = 1;
            if (op == 2 && addrs.size() == 0) op = 3;
            exp_sp = 12'hFFF - 12'(stk.size());
            next_pend = 0;
            d = 16'($urandom);
            case (op)
                0: begin
                    push(2'b00, d, 32'($urandom), 3'($urandom), s);
                    checks++; if ({s.we, s.re, s.addr, s.wdata} !== {2'b10, exp_sp, d}) begin errors++; $display("FAIL rnd_push[%0d]: we=%b re=%b addr=%h wdata=%h want 1 0 %h %h", i, s.we, s.re, s.addr, s.wdata, exp_sp, d); end
                    stk.push_back(d);
                end
                1: begin
                    pop(0, 0, 0, s);
                    checks++; if ({s.we, s.re, s.addr} !== {2'b01, exp_sp + 12'd1}) begin errors++; $display("FAIL rnd_pop[%0d]: we=%b re=%b addr=%h want 0 1 %h", i, s.we, s.re, s.addr, exp_sp + 12'd1); end
                    exp_q.push_back(stk.pop_back());
                    next_pend = 1;
                end
                2: begin
                    a = addrs[$urandom_range(0, addrs.size() - 1)];
                    step(1, 0, 0, 2'b00, 1, 1, 1, a, 16'h0, 32'h0, 3'h0, s);
                    checks++; if ({s.we, s.re, s.addr} !== {2'b01, a}) begin errors++; $display("FAIL rnd_load[%0d]: we=%b re=%b addr=%h want 0 1 %h", i, s.we, s.re, s.addr, a); end
                    exp_q.push_back(ram_m[int'(a)]);
                    next_pend = 1;
                end
                3: begin
                    a = 12'($urandom_range(0, 12'h7FF));
                    step(0, 1, 0, 2'b00, 0, 0, 0, a, d, 32'h0, 3'h0, s);
                    checks++; if ({s.we, s.re, s.addr, s.wdata} !== {2'b10, a, d}) begin errors++; $display("FAIL rnd_store[%0d]: we=%b re=%b addr=%h wdata=%h want 1 0 %h %h", i, s.we, s.re, s.addr, s.wdata, a, d); end
                    ram_m[int'(a)] = d;
                    addrs.push_back(a);
                end
                default: begin
                    idle(s);
                    checks++; if ({s.we, s.re} !== 2'b00) begin errors++; $display("FAIL rnd_idle[%0d]: we=%b re=%b want 0 0", i, s.we, s.re); end
                end
            endcase
            checks++; if (s.sp !== exp_sp) begin errors++; $display("FAIL rnd_sp[%0d]: got %h want %h", i, s.sp, exp_sp); end
            checks++; if ({s.lv, s.rv, s.cv, s.fault} !== {pend, 3'b000}) begin errors++; $display("FAIL rnd_flags[%0d]: lv=%b rv=%b cv=%b fault=%b want %b 0 0 0", i, s.lv, s.rv, s.cv, s.fault, pend); end
            if (pend) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (s.ld !== e) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, s.ld, e); end
            end
            pend = next_pend;
        end
        idle(s);
        checks++; if (s.lv !== pend) begin errors++; $display("FAIL rnd_drain: lv=%b want %b", s.lv, pend); end
        if (pend) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            checks++; if (s.ld !== e) begin errors++; $display("FAIL rnd_drain_data: got %h want %h", s.ld, e); end
        end
    endtask

    task automatic test_reset_mid_ret;
        snap_t s;
        do_reset();
        push(2'b01, 16'h0, 32'hABCD_5678, 3'h0, s);
        push(2'b10, 16'h0, 32'hABCD_5678, 3'h0, s);
        pop(0, 1, 0, s);
        rst = 1'b1;
        #2;
        checks++; if ({ret_pc_valid, load_valid, sp_out} !== {2'b00, 12'hFFF}) begin errors++; $display("FAIL midrst_async: rv=%b lv=%b sp=%h want 0 0 fff", ret_pc_valid, load_valid, sp_out); end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(s);
        checks++; if ({s.rv, s.fault} !== 2'b00) begin errors++; $display("FAIL midrst_after: rv=%b fault=%b want 0 0", s.rv, s.fault); end
        push(2'b00, 16'h7777, 32'h0, 3'h0, s);
        pop(1, 0, 0, s);
        idle(s);
        checks++; if ({s.rv, s.rpc} !== {1'b1, 32'h7777_0000}) begin errors++; $display("FAIL midrst_pc1: rv=%b pc=%h want 1 77770000", s.rv, s.rpc); end
    endtask

    task automatic test_empty_fault;
        snap_t s;
        do_reset();
        pop(0, 0, 0, s);
        checks++; if ({s.re, s.fault} !== 2'b00) begin errors++; $display("FAIL empty_issue: re=%b fault=%b want 0 0", s.re, s.fault); end
        idle(s);
        checks++; if ({s.lv, s.sp, s.fault} !== {1'b0, 12'hFFF, 1'b1}) begin errors++; $display("FAIL empty_after: lv=%b sp=%h fault=%b want 0 fff 1", s.lv, s.sp, s.fault); end
        push(2'b00, 16'h1234, 32'h0, 3'h0, s);
        pop(0, 0, 0, s);
        repeat (3) idle(s);
        checks++; if ({s.sp, s.fault} !== {12'hFFF, 1'b1}) begin errors++; $display("FAIL empty_sticky: sp=%h fault=%b want fff 1", s.sp, s.fault); end
    endtask

    task automatic test_conflict;
        snap_t s;
        do_reset();
        step(1, 1, 1, 2'b00, 0, 0, 0, 12'h0, 16'hBEEF, 32'h0, 3'h0, s);
        checks++; if ({s.we, s.re, s.addr, s.wdata} !== {2'b10, 12'hFFF, 16'hBEEF}) begin errors++; $display("FAIL conflict_issue: we=%b re=%b addr=%h wdata=%h want 1 0 fff beef", s.we, s.re, s.addr, s.wdata); end
        idle(s);
        checks++; if ({s.lv, s.sp, s.fault} !== {1'b0, 12'hFFE, 1'b1}) begin errors++; $display("FAIL conflict_after: lv=%b sp=%h fault=%b want 0 ffe 1", s.lv, s.sp, s.fault); end
    endtask

    task automatic test_full;
        snap_t s;
        do_reset();
        for (int i = 0; i < 4095; i++) push(2'b00, 16'(i), 32'h0, 3'h0, s);
        push(2'b00, 16'hDEAD, 32'h0, 3'h0, s);
        checks++; if ({s.we, s.sp, s.fault} !== {1'b0, 12'h000, 1'b0}) begin errors++; $display("FAIL full_issue: we=%b sp=%h fault=%b want 0 000 0", s.we, s.sp, s.fault); end
        idle(s);
        checks++; if ({s.sp, s.fault} !== {12'h000, 1'b1}) begin errors++; $display("FAIL full_after: sp=%h fault=%b want 000 1", s.sp, s.fault); end
        pop(0, 0, 0, s);
        idle(s);
        checks++; if ({s.lv, s.ld, s.sp} !== {1'b1, 16'd4094, 12'h001}) begin errors++; $display("FAIL full_pop: lv=%b ld=%h sp=%h want 1 0ffe 001", s.lv, s.ld, s.sp); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        test_reset();
        test_call_ret();
        test_int_rti();
        test_random();
        test_reset_mid_ret();
        test_empty_fault();
        test_conflict();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
